ltc232x_capture: RTL and testbench
==================================

Name: ltc232x_capture

Overview:
Parametrised serial-ADC capture engine for the LTC2324/2323/2321 family (1–4 lanes, 12/14/16 bit). It generates CNV and a free-running-domain SCK as registered outputs, with no gated clock. It samples all SDO lanes synchronously in clk and presents one word per conversion on a valid/ready stream toward the DMA packer. The sample period is run-time programmable, and the block adds overrun detection and clean stop semantics.

Parameters:
NUM_CH, 4, number of SDO lanes/channels (1..4)
DATA_W, 16, bits per channel (12, 14 or 16)
TCNVH_CYC, 4, clk cycles CNV held high (≥30 ns)
TCONV_CYC, 25, clk cycles waited after CNV falls before first SCK (≥220 ns)
SCK_HALF, 1, clk cycles per SCK half-period (1..8)
PERIOD_W, 16, width of period_cyc

Ports:
clk  in  1  system clock (110 MHz nominal)
rst_n  in  1  reset
sample_en  in  1  run request, level
period_cyc  in  PERIOD_W  conversion period in clk cycles; sampled at each CNV rise
cnv  out  1  ADC CNV, registered
sck  out  1  ADC SCK, registered
sdo  in  NUM_CH  ADC serial data lanes, lane i = channel i
data  out  NUM_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
data_valid  out  1  word available
data_ready  in  1  consumer accepts
overrun  out  1  sticky: a word was dropped
clr_overrun  in  1  synchronous clear of overrun
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: rst_n is asynchronous, active-low; the clock is clk. All outputs are 0 during reset: cnv, sck, data, data_valid, overrun, busy. The FSM goes to IDLE and all counters clear. Reset mid-conversion aborts the conversion and discards partial data.
- MIN_PERIOD = TCNVH_CYC + TCONV_CYC + 2*SCK_HALF*DATA_W + 1. The effective period is max(period_cyc, MIN_PERIOD), latched at the CNV rise.
- FSM states and transitions:
  - IDLE → CNVH when sample_en = 1.
  - CNVH: cnv = 1 for exactly TCNVH_CYC cycles, then → CONV.
  - CONV: TCONV_CYC cycles, then → SHIFT.
  - SHIFT: exactly DATA_W SCK pulses. SCK starts low, goes high for SCK_HALF cycles, then low for SCK_HALF cycles. On the clk edge that drives SCK high→low, every lane shifts in sdo[i], MSB first. After the last falling edge → WAIT.
  - WAIT: holds until the period counter (started at the CNV rise) reaches effective period − 1. Then → CNVH if sample_en = 1, else → IDLE.
- Shift timing: sck is low in every state except SHIFT.
- Stop semantics: sample_en is sampled only in IDLE and at the end of WAIT. Deasserting it mid-conversion completes and delivers the current word.
- Output register: one-deep holding register.
  - data_valid rises on the cycle after the last bit is captured, carrying all NUM_CH channels.
  - A transfer occurs when data_valid & data_ready. data_valid clears the next cycle unless a new word loads in the same cycle; then data_valid stays high with the new data.
  - data is stable while data_valid & !data_ready.
- Overrun: a word completes while data_valid = 1 and data_ready = 0.
  - The new word is dropped, the old word is kept, and overrun is set.
  - clr_overrun clears overrun. Set wins over a simultaneous clear.
- Width rules: unused sdo lanes do not exist (width NUM_CH). The period counter is PERIOD_W wide and saturates, so it never wraps.

Decomposition:
- Package ltc232x_pkg:
  - FSM state enum (IDLE, CNVH, CONV, SHIFT, WAIT).
  - MIN_PERIOD calculation function.
  - Parameter legality checks (NUM_CH 1..4, DATA_W ∈ {12, 14, 16}, SCK_HALF 1..8).
- One sub-module, ltc232x_lane: a DATA_W-bit MSB-first shift register with a shift-enable and clear-on-CNV, instantiated NUM_CH times via generate.

Test Plan:
1. Defaults, period_cyc = 110, sdo lanes driven by a model returning 0xA5C3, 0x1234, 0xFFFF, 0x0001, data_ready = 1.
   - Expected: cnv high 4 cycles, first sck rise at cycle 29 after the CNV rise, 16 sck pulses.
   - data = {0x0001, 0xFFFF, 0x1234, 0xA5C3}.
   - data_valid high 1 cycle at cycle 62; next CNV rise at cycle 110.
2. period_cyc = 10 (below MIN_PERIOD = 62) → CNV-to-CNV spacing exactly 62 cycles, every word correct.
3. data_ready = 0 for 3 conversions → first word held unchanged, overrun = 1 after the second completion. clr_overrun → overrun = 0. Raise ready → first word transferred.
4. sample_en dropped during SHIFT → current word delivered, no further CNV, busy = 0 at the end of WAIT.
5. rst_n asserted mid-SHIFT → cnv, sck, data_valid = 0 immediately. After release and sample_en = 1, the next word is correct with no stale bits.
6. NUM_CH = 1, DATA_W = 12, SCK_HALF = 2 → 12 sck pulses of 4-cycle period, data = 0xABC from model, MIN_PERIOD = 78.

Source files
------------

// File: rtl/ltc232x_pkg.sv
// Shared definitions for the LTC232x serial-ADC capture engine:
// FSM state encodings, minimum-period arithmetic and parameter legality.
package ltc232x_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CNVH  = 3'd1,
        CONV  = 3'd2,
        SHIFT = 3'd3,
        WAIT  = 3'd4
    } state_e;

    // Flat constants keep the state register a plain logic vector.
    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_CNVH  = CNVH;
    localparam logic [2:0] ST_CONV  = CONV;
    localparam logic [2:0] ST_SHIFT = SHIFT;
    localparam logic [2:0] ST_WAIT  = WAIT;

    function automatic int unsigned min_period(input int unsigned tcnvh,
                                               input int unsigned tconv,
                                               input int unsigned sck_half,
                                               input int unsigned data_w);
        return tcnvh + tconv + 2 * sck_half * data_w + 1;
    endfunction

    function automatic bit params_legal(input int unsigned num_ch,
                                        input int unsigned data_w,
                                        input int unsigned sck_half);
        return (num_ch >= 1) && (num_ch <= 4) &&
               ((data_w == 12) || (data_w == 14) || (data_w == 16)) &&
               (sck_half >= 1) && (sck_half <= 8);
    endfunction

endpackage

// File: rtl/ltc232x_lane.sv
// One SDO lane: MSB-first shift register, cleared at the start of each conversion.
module ltc232x_lane
    import ltc232x_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              shift_en_i,
    input  logic              sdo_i,
    output logic [DATA_W-1:0] word_o
);

    logic [DATA_W-1:0] word_q, word_d;

    always_comb begin
        word_d = word_q;
        if (clr_i) begin
            word_d = '0;
        end else if (shift_en_i) begin
            word_d = {word_q[DATA_W-2:0], sdo_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/ltc232x_capture.sv
// LTC2324/2323/2321 capture engine: registered CNV/SCK generation, per-lane
// shift capture, one-deep valid/ready output register with sticky overrun.
module ltc232x_capture
    import ltc232x_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned TCNVH_CYC = 4,
    parameter int unsigned TCONV_CYC = 25,
    parameter int unsigned SCK_HALF  = 1,
    parameter int unsigned PERIOD_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_en,
    input  logic [PERIOD_W-1:0]        period_cyc,
    output logic                       cnv,
    output logic                       sck,
    input  logic [NUM_CH-1:0]          sdo,
    output logic [NUM_CH*DATA_W-1:0]   data,
    output logic                       data_valid,
    input  logic                       data_ready,
    output logic                       overrun,
    input  logic                       clr_overrun,
    output logic                       busy
);

    localparam int unsigned MIN_P = min_period(TCNVH_CYC, TCONV_CYC, SCK_HALF, DATA_W);
    localparam logic [PERIOD_W-1:0] MIN_PERIOD_V = PERIOD_W'(MIN_P);
    localparam int unsigned TMAX0 = (TCNVH_CYC > TCONV_CYC) ? TCNVH_CYC : TCONV_CYC;
    localparam int unsigned TMAX  = (TMAX0 > SCK_HALF) ? TMAX0 : SCK_HALF;
    localparam int unsigned TW    = $clog2(TMAX + 1);
    localparam int unsigned BW    = $clog2(DATA_W + 1);

    if (!params_legal(NUM_CH, DATA_W, SCK_HALF) ||
        (64'(MIN_P) >= (64'd1 << PERIOD_W))) begin : g_bad_params
        $error("ltc232x_capture: illegal NUM_CH/DATA_W/SCK_HALF/PERIOD_W");
    end

    logic [2:0]                state_q, state_d;
    logic                      cnv_q, cnv_d;
    logic                      sck_q, sck_d;
    logic [TW-1:0]             tcnt_q, tcnt_d;
    logic [BW-1:0]             bcnt_q, bcnt_d;
    logic [PERIOD_W-1:0]       per_cnt_q, per_cnt_d;
    logic [PERIOD_W-1:0]       eff_q, eff_d;
    logic                      done_q, done_d;
    logic [NUM_CH*DATA_W-1:0]  data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      ovr_q, ovr_d;
    logic                      start;
    logic                      shift_en;
    logic                      load;
    logic                      drop;
    logic [NUM_CH*DATA_W-1:0]  lane_words;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        ltc232x_lane #(
            .DATA_W(DATA_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr_i     (start),
            .shift_en_i(shift_en),
            .sdo_i     (sdo[g]),
            .word_o    (lane_words[g*DATA_W +: DATA_W])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnv_d     = cnv_q;
        sck_d     = sck_q;
        tcnt_d    = tcnt_q;
        bcnt_d    = bcnt_q;
        per_cnt_d = per_cnt_q;
        eff_d     = eff_q;
        done_d    = 1'b0;
        shift_en  = 1'b0;
        start     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sample_en) start = 1'b1;
            end
            ST_CNVH: begin
                if (tcnt_q == TW'(TCNVH_CYC - 1)) begin
                    state_d = ST_CONV;
                    cnv_d   = 1'b0;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            ST_CONV: begin
                if (tcnt_q == TW'(TCONV_CYC - 1)) begin
                    state_d = ST_SHIFT;
                    sck_d   = 1'b1;
                    tcnt_d  = '0;
                    bcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            ST_SHIFT: begin
                // Each lane samples on the edge that drives SCK low; the
                // low half of the last pulse still completes before WAIT.
                if (tcnt_q == TW'(SCK_HALF - 1)) begin
                    tcnt_d = '0;
                    if (sck_q) begin
                        sck_d    = 1'b0;
                        shift_en = 1'b1;
                        bcnt_d   = bcnt_q + BW'(1);
                    end else if (bcnt_q == BW'(DATA_W)) begin
                        state_d = ST_WAIT;
                        done_d  = 1'b1;
                    end else begin
                        sck_d = 1'b1;
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            ST_WAIT: begin
                if (per_cnt_q >= eff_q - PERIOD_W'(1)) begin
                    if (sample_en) start = 1'b1;
                    else           state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            state_d   = ST_CNVH;
            cnv_d     = 1'b1;
            tcnt_d    = '0;
            per_cnt_d = '0;
            eff_d     = (period_cyc > MIN_PERIOD_V) ? period_cyc : MIN_PERIOD_V;
        end else if (per_cnt_q != '1) begin
            per_cnt_d = per_cnt_q + PERIOD_W'(1);
        end
    end

    always_comb begin
        load   = done_q & (~valid_q | data_ready);
        drop   = done_q & valid_q & ~data_ready;
        data_d = load ? lane_words : data_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (valid_q & data_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        ovr_d = drop ? 1'b1 : (clr_overrun ? 1'b0 : ovr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnv_q     <= 1'b0;
            sck_q     <= 1'b0;
            tcnt_q    <= '0;
            bcnt_q    <= '0;
            per_cnt_q <= '0;
            eff_q     <= '0;
            done_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnv_q     <= cnv_d;
            sck_q     <= sck_d;
            tcnt_q    <= tcnt_d;
            bcnt_q    <= bcnt_d;
            per_cnt_q <= per_cnt_d;
            eff_q     <= eff_d;
            done_q    <= done_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    assign cnv        = cnv_q;
    assign sck        = sck_q;
    assign data       = data_q;
    assign data_valid = valid_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ltc232x_capture.sv
// Directed bench for ltc232x_capture: default 4x16 instance plus a 1x12 SCK_HALF=2 instance.
module tb_ltc232x_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sample_en, sample_en2;
    logic [15:0] period_cyc, period2;
    logic        ready, ready2, clr_ovr, clr_ovr2;
    logic [3:0]  sdo;
    logic        sdo2;
    logic        cnv, sck, valid, ovr, busy;
    logic [63:0] data;
    logic        cnv2, sck2, valid2, ovr2, busy2;
    logic [11:0] data2;

    ltc232x_capture #(
        .NUM_CH(4), .DATA_W(16), .TCNVH_CYC(4), .TCONV_CYC(25), .SCK_HALF(1), .PERIOD_W(16)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .period_cyc(period_cyc),
        .cnv(cnv), .sck(sck), .sdo(sdo), .data(data), .data_valid(valid),
        .data_ready(ready), .overrun(ovr), .clr_overrun(clr_ovr), .busy(busy)
    );

    ltc232x_capture #(
        .NUM_CH(1), .DATA_W(12), .TCNVH_CYC(4), .TCONV_CYC(25), .SCK_HALF(2), .PERIOD_W(16)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en2), .period_cyc(period2),
        .cnv(cnv2), .sck(sck2), .sdo(sdo2), .data(data2), .data_valid(valid2),
        .data_ready(ready2), .overrun(ovr2), .clr_overrun(clr_ovr2), .busy(busy2)
    );

    // ADC model: bit index restarts at CNV rise and advances after each SCK fall
    logic [15:0] adc_w [4];
    logic [11:0] adc_w2;
    logic [4:0]  idx  = '0;
    logic [4:0]  idx2 = '0;

    always @(posedge cnv or negedge sck) begin
        if (cnv) idx <= '0;
        else if (idx != 5'd31) idx <= idx + 5'd1;
    end

    always @(posedge cnv2 or negedge sck2) begin
        if (cnv2) idx2 <= '0;
        else if (idx2 != 5'd31) idx2 <= idx2 + 5'd1;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sdo[i] = (idx < 5'd16) ? adc_w[i][4'(5'd15 - idx)] : 1'b0;
        end
        sdo2 = (idx2 < 5'd12) ? adc_w2[4'(5'd11 - idx2)] : 1'b0;
    end

    logic        use2 = 1'b0;
    logic        m_cnv, m_sck, m_valid;
    logic [63:0] m_data;
    always_comb begin
        m_cnv   = use2 ? cnv2   : cnv;
        m_sck   = use2 ? sck2   : sck;
        m_valid = use2 ? valid2 : valid;
        m_data  = use2 ? {52'd0, data2} : data;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int r_cnvh, r_sck1, r_sck2, r_rises, r_vfirst, r_vcnt, r_next;
    logic [63:0] r_data;
    bit ok;
    int cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rise(output bit found);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic p;
            p = m_cnv;
            tick();
            if (m_cnv && !p) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Starts at the sample point of a CNV rise (offset 0), ends at the next rise.
    task automatic observe(input int maxc, input int ready_low_at);
        logic pc, ps;
        r_cnvh = 0; r_sck1 = -1; r_sck2 = -1; r_rises = 0;
        r_vfirst = -1; r_vcnt = 0; r_next = -1; r_data = '0;
        pc = 1'b1; ps = 1'b0;
        for (int t = 0; t <= maxc; t++) begin
            if (t == ready_low_at) ready = 1'b0;
            if (t > 0 && m_valid) begin
                if (r_vfirst < 0) begin
                    r_vfirst = t;
                    r_data   = m_data;
                end
                r_vcnt++;
            end
            if (t > 0 && m_cnv && !pc) begin
                r_next = t;
                break;
            end
            if (m_cnv) r_cnvh++;
            if (m_sck && !ps) begin
                r_rises++;
                if (r_sck1 < 0) r_sck1 = t;
                else if (r_sck2 < 0) r_sck2 = t;
            end
            pc = m_cnv;
            ps = m_sck;
            if (t < maxc) tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; sample_en = 1'b0; sample_en2 = 1'b0;
        period_cyc = 16'd110; period2 = 16'd10;
        ready = 1'b1; ready2 = 1'b1; clr_ovr = 1'b0; clr_ovr2 = 1'b0;
        adc_w[0] = 16'hA5C3; adc_w[1] = 16'h1234; adc_w[2] = 16'hFFFF; adc_w[3] = 16'h0001;
        adc_w2 = 12'hABC;
        tick(); tick(); tick();

        chk("rst_cnv",   64'(cnv),   64'd0);
        chk("rst_sck",   64'(sck),   64'd0);
        chk("rst_data",  data,       64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_ovr",   64'(ovr),   64'd0);
        chk("rst_busy",  64'(busy),  64'd0);

        // Test 1: defaults, period 110
        rst_n = 1'b1;
        sample_en = 1'b1;
        wait_rise(ok);
        chk("t1_rise_seen", 64'(ok), 64'd1);
        observe(300, -1);
        chk("t1_cnv_high",   64'(r_cnvh),   64'd4);
        chk("t1_first_sck",  64'(r_sck1),   64'd29);
        chk("t1_second_sck", 64'(r_sck2),   64'd31);
        chk("t1_sck_pulses", 64'(r_rises),  64'd16);
        chk("t1_valid_at",   64'(r_vfirst), 64'd62);
        chk("t1_valid_cnt",  64'(r_vcnt),   64'd1);
        chk("t1_data",       r_data,        64'h0001_FFFF_1234_A5C3);
        chk("t1_next_cnv",   64'(r_next),   64'd110);
        chk("t1_ovr",        64'(ovr),      64'd0);

        // Test 2: period below minimum clamps to 62 (conversion 2 already latched 110)
        period_cyc = 16'd10;
        adc_w[0] = 16'h0F0F; adc_w[1] = 16'hF0F0; adc_w[2] = 16'h8000; adc_w[3] = 16'h7FFE;
        observe(300, -1);
        chk("t2a_next_cnv", 64'(r_next), 64'd110);
        chk("t2a_data",     r_data,      64'h7FFE_8000_F0F0_0F0F);
        adc_w[0] = 16'h1357; adc_w[1] = 16'h2468; adc_w[2] = 16'h0000; adc_w[3] = 16'hDEAD;
        observe(300, -1);
        chk("t2b_next_cnv", 64'(r_next),   64'd62);
        chk("t2b_valid_at", 64'(r_vfirst), 64'd62);
        chk("t2b_data",     r_data,        64'hDEAD_0000_2468_1357);
        adc_w[0] = 16'hBEEF; adc_w[1] = 16'hCAFE; adc_w[2] = 16'h5555; adc_w[3] = 16'hAAAA;
        observe(300, -1);
        chk("t2c_next_cnv", 64'(r_next), 64'd62);
        chk("t2c_valid_cnt", 64'(r_vcnt), 64'd1);
        chk("t2c_data",     r_data,      64'hAAAA_5555_CAFE_BEEF);

        // Test 3: consumer stalls for three conversions
        adc_w[0] = 16'h1111; adc_w[1] = 16'h2222; adc_w[2] = 16'h3333; adc_w[3] = 16'h4444;
        observe(300, 1);
        chk("t3a_data", r_data,    64'h4444_3333_2222_1111);
        chk("t3a_ovr",  64'(ovr),  64'd0);
        adc_w[0] = 16'h9999; adc_w[1] = 16'h8888; adc_w[2] = 16'h7777; adc_w[3] = 16'h6666;
        observe(300, -1);
        chk("t3b_next_cnv", 64'(r_next),  64'd62);
        chk("t3b_held",     r_data,       64'h4444_3333_2222_1111);
        chk("t3b_held_end", data,         64'h4444_3333_2222_1111);
        chk("t3b_ovr",      64'(ovr),     64'd1);
        chk("t3b_valid",    64'(valid),   64'd1);
        adc_w[0] = 16'h0102; adc_w[1] = 16'h0304; adc_w[2] = 16'h0506; adc_w[3] = 16'h0708;
        observe(300, -1);
        chk("t3c_held", data,     64'h4444_3333_2222_1111);
        chk("t3c_ovr",  64'(ovr), 64'd1);
        adc_w[0] = 16'hC001; adc_w[1] = 16'hD00D; adc_w[2] = 16'hF00D; adc_w[3] = 16'h0BAD;
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("t3_ovr_clr",   64'(ovr),   64'd0);
        chk("t3_valid_pre", 64'(valid), 64'd1);
        chk("t3_data_pre",  data,       64'h4444_3333_2222_1111);
        ready = 1'b1;
        tick();
        chk("t3_valid_post", 64'(valid), 64'd0);
        wait_rise(ok);
        chk("t3d_rise_seen", 64'(ok),    64'd1);
        chk("t3d_valid",     64'(valid), 64'd1);
        chk("t3d_data",      data,       64'h0BAD_F00D_D00D_C001);
        chk("t3d_ovr",       64'(ovr),   64'd0);

        // Test 4: run request dropped mid-SHIFT
        adc_w[0] = 16'h5A5A; adc_w[1] = 16'hA5A5; adc_w[2] = 16'h0FF0; adc_w[3] = 16'hF00F;
        for (int i = 0; i < 40; i++) tick();
        sample_en = 1'b0;
        for (int i = 0; i < 21; i++) tick();
        chk("t4_busy_wait", 64'(busy), 64'd1);
        tick();
        chk("t4_valid",   64'(valid), 64'd1);
        chk("t4_data",    data,       64'hF00F_0FF0_A5A5_5A5A);
        chk("t4_busy_end", 64'(busy), 64'd0);
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (cnv) cnt++;
        end
        chk("t4_no_cnv",  64'(cnt),  64'd0);
        chk("t4_idle",    64'(busy), 64'd0);

        // Test 5: asynchronous reset mid-SHIFT with a word pending
        period_cyc = 16'd80;
        ready = 1'b0;
        adc_w[0] = 16'h0A0B; adc_w[1] = 16'h0C0D; adc_w[2] = 16'h0E0F; adc_w[3] = 16'h1020;
        sample_en = 1'b1;
        wait_rise(ok);
        chk("t5_rise_seen", 64'(ok), 64'd1);
        observe(300, -1);
        chk("t5_next_cnv", 64'(r_next), 64'd80);
        chk("t5_data",     r_data,      64'h1020_0E0F_0C0D_0A0B);
        adc_w[0] = 16'hEEEE; adc_w[1] = 16'hDDDD; adc_w[2] = 16'hCCCC; adc_w[3] = 16'hBBBB;
        for (int i = 0; i < 41; i++) tick();
        chk("t5_sck_pre",   64'(sck),   64'd1);
        chk("t5_valid_pre", 64'(valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_cnv",   64'(cnv),   64'd0);
        chk("t5_rst_sck",   64'(sck),   64'd0);
        chk("t5_rst_valid", 64'(valid), 64'd0);
        chk("t5_rst_data",  data,       64'd0);
        chk("t5_rst_busy",  64'(busy),  64'd0);
        tick(); tick(); tick();
        adc_w[0] = 16'h6789; adc_w[1] = 16'h3210; adc_w[2] = 16'hFEDC; adc_w[3] = 16'h8001;
        ready = 1'b1;
        rst_n = 1'b1;
        wait_rise(ok);
        chk("t5b_rise_seen", 64'(ok), 64'd1);
        observe(300, -1);
        chk("t5b_valid_at", 64'(r_vfirst), 64'd62);
        chk("t5b_data",     r_data,        64'h8001_FEDC_3210_6789);
        chk("t5b_next_cnv", 64'(r_next),   64'd80);

        // Test 6: 1 lane, 12 bits, SCK_HALF = 2, MIN_PERIOD = 78
        sample_en = 1'b0;
        use2 = 1'b1;
        sample_en2 = 1'b1;
        wait_rise(ok);
        chk("t6_rise_seen", 64'(ok), 64'd1);
        observe(300, -1);
        chk("t6_cnv_high",   64'(r_cnvh),   64'd4);
        chk("t6_first_sck",  64'(r_sck1),   64'd29);
        chk("t6_second_sck", 64'(r_sck2),   64'd33);
        chk("t6_sck_pulses", 64'(r_rises),  64'd12);
        chk("t6_valid_at",   64'(r_vfirst), 64'd78);
        chk("t6_data",       r_data,        64'hABC);
        chk("t6_next_cnv",   64'(r_next),   64'd78);
        adc_w2 = 12'h5A3;
        observe(300, -1);
        chk("t6b_data",     r_data,      64'h5A3);
        chk("t6b_next_cnv", 64'(r_next), 64'd78);
        sample_en2 = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk("t6_busy2_end", 64'(busy2), 64'd0);
        chk("t6_ovr2",      64'(ovr2),  64'd0);
        chk("t6_busy1_end", 64'(busy),  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
